// File: rtl/ahb_apb_flash_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : ahb_apb_flash_bridge                                             |
// | Brief   : AHB-Lite slave to single-strobe APB master for a 256-word flash  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module ahb_apb_flash_bridge #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          ADDR_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hsel,
    input  logic [1:0]        htrans,
    input  logic              hwrite,
    input  logic [2:0]        hsize,
    input  logic [31:0]       haddr,
    input  logic [31:0]       hwdata,
    input  logic              hready,
    output logic              hreadyout,
    output logic              hresp,
    output logic [31:0]       hrdata,
    output logic              apb_sel,
    output logic              apb_write,
    output logic [ADDR_W-1:0] apb_addr,
    output logic [31:0]       apb_wdata,
    input  logic [31:0]       apb_rdata
);

    localparam int HI = ADDR_W + 2;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETUP  = 3'd1,
        S_ACCESS = 3'd2,
        S_RDWAIT = 3'd3,
        S_DONE   = 3'd4,
        S_ERR1   = 3'd5,
        S_ERR2   = 3'd6
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              addr_valid;
    logic              addr_legal;
    logic              accept;
    logic [ADDR_W-1:0] addr_lat;
    logic              write_lat;
    logic              unused;

    assign unused     = htrans[0];
    assign addr_valid = hsel & hready & htrans[1];
    // The window is aligned to its own size, so an upper-bit match is a full range check.
    assign addr_legal = (hsize == 3'b010) && (haddr[1:0] == 2'b00) &&
                        (haddr[31:HI] == BASE_ADDR[31:HI]);
    assign accept     = (state == S_IDLE) || (state == S_DONE) || (state == S_ERR2);

    always_comb begin
        state_nxt = state;
        case (state)
            S_SETUP:  state_nxt = S_ACCESS;
            S_ACCESS: state_nxt = write_lat ? S_DONE : S_RDWAIT;
            S_RDWAIT: state_nxt = S_DONE;
            S_ERR1:   state_nxt = S_ERR2;
            S_IDLE, S_DONE, S_ERR2: begin
                if (addr_valid)
                    state_nxt = addr_legal ? S_SETUP : S_ERR1;
                else
                    state_nxt = S_IDLE;
            end
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            hreadyout <= 1'b1;
            hresp     <= 1'b0;
            hrdata    <= 32'h0;
            apb_sel   <= 1'b0;
            apb_write <= 1'b0;
            apb_addr  <= '0;
            apb_wdata <= 32'h0;
            addr_lat  <= '0;
            write_lat <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept && addr_valid && addr_legal) begin
                addr_lat  <= haddr[HI-1:2];
                write_lat <= hwrite;
            end
            if (state == S_SETUP) begin
                apb_addr  <= addr_lat;
                apb_write <= write_lat;
                if (write_lat)
                    apb_wdata <= hwdata;
            end
            if (state == S_RDWAIT)
                hrdata <= apb_rdata;
            apb_sel   <= (state_nxt == S_ACCESS);
            hreadyout <= (state_nxt == S_IDLE) || (state_nxt == S_DONE) || (state_nxt == S_ERR2);
            hresp     <= (state_nxt == S_ERR1) || (state_nxt == S_ERR2);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_apb_flash_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_ahb_apb_flash_bridge                                          |
// | Brief   : Randomized AHB master + flash model bench for the APB bridge     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_ahb_apb_flash_bridge;

    localparam logic [31:0] BASE = 32'h0002_0000;
    localparam int          WIN  = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        hsel;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [31:0] haddr;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic        apb_sel;
    logic        apb_write;
    logic [7:0]  apb_addr;
    logic [31:0] apb_wdata;
    logic [31:0] apb_rdata;

    int n_checks = 0;
    int n_fail   = 0;
    int strobes  = 0;
    int cyc      = 0;
    int sel_cyc[$];
    logic        prev_sel = 1'b0;
    logic [7:0]  mon_addr;
    logic        mon_write;
    logic [31:0] mon_wdata;
    logic [31:0] fmem[256];
    logic [31:0] ref_mem[256];
    logic [31:0] last_rd;

    ahb_apb_flash_bridge #(.BASE_ADDR(BASE), .ADDR_W(8)) dut (
        .clk(clk), .reset(reset), .hsel(hsel), .htrans(htrans), .hwrite(hwrite),
        .hsize(hsize), .haddr(haddr), .hwdata(hwdata), .hready(hready),
        .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata), .apb_sel(apb_sel),
        .apb_write(apb_write), .apb_addr(apb_addr), .apb_wdata(apb_wdata),
        .apb_rdata(apb_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Flash slave: read data is valid only in the cycle after the strobe, garbage otherwise.
    always @(posedge clk) begin
        if (apb_sel && apb_write) fmem[apb_addr] <= apb_wdata;
        if (apb_sel && !apb_write) apb_rdata <= fmem[apb_addr];
        else apb_rdata <= $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (apb_sel) begin
            strobes++;
            sel_cyc.push_back(cyc);
            mon_addr  = apb_addr;
            mon_write = apb_write;
            mon_wdata = apb_wdata;
            if (prev_sel) chk("sel_b2b", 32'd1, 32'd0);
        end
        prev_sel = apb_sel;
    end

    task automatic bus_idle();
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hsize = 3'b010; hready = 1'b1;
    endtask

    // One AHB transfer; the address phase lands in whatever cycle the call starts in.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] data);
        logic  legal;
        int    word;
        int    n;
        int    exp_lat;
        int    s0;
        legal = (size == 3'b010) && (addr[1:0] == 2'b00) &&
                ({32'h0, addr} >= {32'h0, BASE}) && ({32'h0, addr} < {32'h0, BASE} + WIN);
        word  = legal ? int'((addr - BASE) / 4) : 0;
        s0    = strobes;
        chk("t0_rdy", hreadyout, 1);
        hsel = 1'b1; htrans = 2'b10; hwrite = wr; hsize = size; haddr = addr; hready = 1'b1;
        @(posedge clk); #1;
        bus_idle();
        hwdata = data;
        n = 1;
        chk("t1_rdy", hreadyout, 0);
        chk("t1_resp", hresp, !legal);
        while (!hreadyout && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        exp_lat = !legal ? 2 : (wr ? 3 : 4);
        chk("latency", n, exp_lat);
        chk("resp_end", hresp, !legal);
        chk("strobes", strobes - s0, legal);
        if (legal) begin
            chk("apb_addr", mon_addr, word);
            chk("apb_write", mon_write, wr);
            if (wr) begin
                chk("apb_wdata", mon_wdata, data);
                ref_mem[word] = data;
            end else begin
                last_rd = ref_mem[word];
            end
        end
        chk("hrdata", hrdata, last_rd);
        hwdata = $urandom;
    endtask

    task automatic ignored(input logic sel, input logic [1:0] trans, input logic rdy);
        int s0;
        s0 = strobes;
        hsel = sel; htrans = trans; hwrite = 1'b1; hsize = 3'b010; haddr = BASE; hready = rdy;
        @(posedge clk); #1;
        bus_idle();
        chk("ign_rdy", hreadyout, 1);
        chk("ign_resp", hresp, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("ign_strobes", strobes - s0, 0);
        chk("ign_rdy2", hreadyout, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int          kind;
        int          w;
        logic [2:0]  sz;
        for (int i = 0; i < 256; i++) begin
            fmem[i]    = i;
            ref_mem[i] = i;
        end
        last_rd = 32'h0;
        reset = 1'b0;
        bus_idle();
        haddr = 32'h0;
        hwdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdy", hreadyout, 1);
        chk("rst_resp", hresp, 0);
        chk("rst_hrdata", hrdata, 0);
        chk("rst_sel", apb_sel, 0);
        chk("rst_write", apb_write, 0);
        chk("rst_addr", apb_addr, 0);
        chk("rst_wdata", apb_wdata, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        xfer(1'b1, BASE + 32'h10, 3'b010, 32'hDEAD_BEEF);
        xfer(1'b0, BASE + 32'h10, 3'b010, 32'h0);

        sel_cyc.delete();
        xfer(1'b1, BASE + 32'h0, 3'b010, 32'd0);
        xfer(1'b1, BASE + 32'h4, 3'b010, 32'd1);
        xfer(1'b1, BASE + 32'h8, 3'b010, 32'd2);
        chk("b2b_count", sel_cyc.size(), 3);
        if (sel_cyc.size() == 3) begin
            chk("b2b_gap1", sel_cyc[1] - sel_cyc[0], 3);
            chk("b2b_gap2", sel_cyc[2] - sel_cyc[1], 3);
        end
        xfer(1'b0, BASE + 32'h0, 3'b010, 32'h0);
        chk("rd0", hrdata, 0);
        xfer(1'b0, BASE + 32'h4, 3'b010, 32'h0);
        chk("rd1", hrdata, 1);
        xfer(1'b0, BASE + 32'h8, 3'b010, 32'h0);
        chk("rd2", hrdata, 2);

        xfer(1'b0, BASE + 32'h400, 3'b010, 32'h0);
        xfer(1'b0, BASE + 32'h2, 3'b010, 32'h0);
        xfer(1'b0, BASE + 32'h4, 3'b000, 32'h0);
        xfer(1'b0, BASE - 32'h4, 3'b010, 32'h0);

        ignored(1'b1, 2'b00, 1'b1);
        ignored(1'b1, 2'b01, 1'b1);
        ignored(1'b0, 2'b10, 1'b1);
        ignored(1'b1, 2'b10, 1'b0);

        xfer(1'b1, BASE + 32'h3FC, 3'b010, 32'h1234_5678);
        xfer(1'b0, BASE + 32'h3FC, 3'b010, 32'h0);
        chk("top_addr", mon_addr, 8'hFF);
        xfer(1'b1, BASE + 32'h400, 3'b010, 32'h0);

        // Reset dropped during the ACCESS cycle of a write.
        hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; hsize = 3'b010;
        haddr = BASE + 32'h14; hready = 1'b1;
        @(posedge clk); #1;
        bus_idle();
        hwdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        chk("acc_sel", apb_sel, 1);
        #1 reset = 1'b0;
        #1;
        chk("mid_sel", apb_sel, 0);
        chk("mid_rdy", hreadyout, 1);
        chk("mid_resp", hresp, 0);
        chk("mid_hrdata", hrdata, 0);
        chk("mid_addr", apb_addr, 0);
        chk("mid_write", apb_write, 0);
        chk("mid_wdata", apb_wdata, 0);
        last_rd = 32'h0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        xfer(1'b0, BASE + 32'h14, 3'b010, 32'h0);
        xfer(1'b1, BASE + 32'h18, 3'b010, 32'hA5A5_0001);
        xfer(1'b0, BASE + 32'h18, 3'b010, 32'h0);

        for (int k = 0; k < 80; k++) begin
            kind = $urandom_range(0, 9);
            w    = $urandom_range(0, 15);
            a    = BASE + 32'(w * 4);
            sz   = 3'b010;
            case (kind)
                0: a = BASE + WIN + 32'($urandom_range(0, 255) * 4);
                1: a = BASE - 32'($urandom_range(1, 256) * 4);
                2: a = a + 32'($urandom_range(1, 3));
                3: sz = 3'($urandom_range(0, 1));
                default: ;
            endcase
            xfer($urandom_range(0, 1) == 1, a, sz, $urandom);
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ahb_apb_flash_bridge.md
Name: ahb_apb_flash_bridge

Overview:
- AHB-Lite slave to simple-APB master bridge, directly upstream of the 256-word flash memory slave.
- Converts single 32-bit AHB word transfers into one-cycle apb_sel strobes.
- Inserts wait states with hreadyout, and returns read data captured one cycle after the APB read strobe.
- Out-of-window, unaligned or non-word transfers get a two-cycle AHB ERROR response and never reach APB.

Parameters:
BASE_ADDR, 32'h0000_0000, byte base of flash window; must be 1 KiB aligned
ADDR_W, 8, APB word-address width; window size = 4*2^ADDR_W bytes

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
hsel  in  1  AHB slave select
htrans  in  2  AHB transfer type
hwrite  in  1  AHB write
hsize  in  3  AHB transfer size
haddr  in  32  AHB byte address
hwdata  in  32  AHB write data, valid in data phase
hready  in  1  AHB bus ready
hreadyout  out  1  slave ready
hresp  out  1  0=OKAY, 1=ERROR
hrdata  out  32  read data
apb_sel  out  1  one-cycle access strobe to flash
apb_write  out  1  1=write, 0=read
apb_addr  out  ADDR_W  word address = haddr[ADDR_W+1:2]
apb_wdata  out  32  write data
apb_rdata  in  32  flash read data, registered by flash one cycle after a read strobe

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-low.
- Reset state: FSM=IDLE, hreadyout=1, hresp=0, hrdata=0, apb_sel=0, apb_write=0, apb_addr=0, apb_wdata=0.
- Reset mid-transfer: all outputs return to reset values immediately. Any in-flight APB access is abandoned (apb_sel drops asynchronously).
- Valid address phase: hsel & hready & htrans[1] (NONSEQ or SEQ), sampled on the rising edge. htrans IDLE/BUSY, or hsel=0, are ignored and the FSM stays put.
- Legality check at address phase: hsize==3'b010, haddr[1:0]==0, and haddr in [BASE_ADDR, BASE_ADDR+4*2^ADDR_W).
  - Legal: latch haddr word index and hwrite; go to SETUP.
  - Illegal: go to ERR1.
- FSM states and outputs:
  - IDLE: hreadyout=1, hresp=0.
  - SETUP (AHB data phase): hreadyout=0. Write: capture hwdata into apb_wdata. Next state ACCESS.
  - ACCESS: apb_sel=1 for exactly this cycle; apb_write/apb_addr/apb_wdata driven from latches; hreadyout=0. Write -> DONE; read -> RDWAIT.
  - RDWAIT: apb_sel=0, hreadyout=0. Capture apb_rdata into hrdata at the end of the cycle. Next state DONE.
  - DONE: hreadyout=1, hresp=0, transfer completes. hrdata holds the read value until the next read capture.
  - ERR1: hreadyout=0, hresp=1. Next state ERR2.
  - ERR2: hreadyout=1, hresp=1. Next state IDLE, or a new transfer is accepted.
- Latency, relative to address phase T0:
  - Write: apb_sel at T2, completes at T3 (2 wait states).
  - Read: apb_sel at T2, hrdata valid and completes at T4 (3 wait states).
- Pipelining: in DONE and ERR2 (hreadyout=1), a valid address phase is accepted (-> SETUP or ERR1); otherwise the next state is IDLE. Back-to-back transfers therefore add no idle cycle.
- apb_addr/apb_write/apb_wdata hold their last values outside ACCESS. Only apb_sel qualifies them.
- apb_sel is never high for 2 consecutive cycles. Exactly one strobe per legal transfer; zero for illegal transfers.
- hrdata is not modified by writes or errors.

Test Plan:
- After reset: write 32'hDEAD_BEEF to BASE_ADDR+0x10, then read it back -> one apb_sel each with apb_addr=8'h04; write completes at T3 (hreadyout=1); read hrdata=32'hDEAD_BEEF at T4, hresp=0 throughout.
- Back-to-back NONSEQ writes to 0x0, 0x4, 0x8, then reads of the same -> apb_sel pulses spaced exactly 3 cycles apart for writes; reads return data 0,1,2 in order.
- Read at BASE_ADDR+0x400 (out of window), at 0x2 (unaligned), and with hsize=3'b000 -> hresp=1 for 2 cycles (hreadyout 0 then 1), apb_sel stays 0, hrdata unchanged.
- htrans=IDLE and BUSY with hsel=1, and NONSEQ with hsel=0 or hready=0 -> no state change, hreadyout=1, no apb_sel.
- Assert reset low during ACCESS of a write -> apb_sel falls immediately; all outputs take reset values; a transfer issued after reset release completes normally.
- Read at word 8'hFF (top of window) -> legal, apb_addr=8'hFF, data returned; BASE_ADDR+0x3FC accepted, BASE_ADDR+0x400 errors.
